// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Initiator side of the data-memory port in the MEM stage. Takes one
//   load/store request at a time, drives the word-wide memory interface and
//   returns sign- or zero-extended load data. The memory only moves aligned
//   32-bit words, so byte and halfword stores are done as read-modify-write.
//
// Optional feature macro:
//   MEM_MISALIGN_TRAP_EN - when defined, a halfword with addr[0]!=0 or a word
//   with addr[1:0]!=0 is rejected with resp_err. When undefined, low address
//   bits are ignored (half uses addr[1], word uses lane 0).
//
// Parameters:
//   MEM_BYTES   memory size in bytes; req_addr >= MEM_BYTES is an error
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req_valid    request present
//   req_ready    controller idle and able to accept
//   req_we       1 store, 0 load
//   req_size     00 byte, 01 half, 10 word, 11 reserved (error)
//   req_sign     load sign-extend (1) or zero-extend (0)
//   req_addr     byte address
//   req_wdata    store data, right-justified
//   resp_valid   one-cycle completion pulse
//   resp_rdata   load result, held until the next load completes
//   resp_err     error flag, valid with resp_valid
//   MemRead      memory read strobe
//   MemWrite     memory write strobe, sampled by memory on posedge
//   addr         word-aligned byte address to memory
//   wd           little-endian write word to memory
//   rd           combinational read word from memory
module mem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] addr,
  output logic [31:0] wd,
  input  logic [31:0] rd
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [1:0]  SZ_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;

  // Request fields latched at accept; the pipeline may change req_* afterwards.
  logic        we_p0;
  logic [1:0]  size_p0;
  logic        sgn_p0;
  logic [31:0] a_p0;
  logic [31:0] wdata_p0;
  // Word to be written: raw store data for word stores, merged word for RMW.
  logic [31:0] wd_p1;

  logic size_bad;
  logic range_bad;
  logic align_bad;
  logic req_bad;

  // Select the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the read word with the low store bits.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          default: r[31:24] = data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) r[31:16] = data[15:0];
        else         r[15:0]  = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  // Request error decode, evaluated on the live request at accept time.
  assign size_bad  = (req_size == SZ_RSVD);
  assign range_bad = (req_addr >= MEM_LIMIT);
`ifdef MEM_MISALIGN_TRAP_EN
  assign align_bad = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign align_bad = 1'b0;
`endif
  assign req_bad = size_bad | range_bad | align_bad;

  assign req_ready = (state == IDLE) & ~rst;

  // Memory side is decoded from state; a reset during WR must not write.
  assign MemRead  = (state == RD);
  assign MemWrite = (state == WR) & ~rst;
  assign addr     = ((state == RD) || (state == WR)) ? {a_p0[31:2], 2'b00} : 32'd0;
  assign wd       = (state == WR) ? wd_p1 : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        // Stage p0: accept and latch the request, route by kind.
        IDLE: begin
          if (req_valid) begin
            we_p0    <= req_we;
            size_p0  <= req_size;
            sgn_p0   <= req_sign;
            a_p0     <= req_addr;
            wdata_p0 <= req_wdata;
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && (req_size == SZ_WORD)) begin
              wd_p1 <= req_wdata;
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        // Stage p1: memory word is on rd; extend for loads or merge for RMW.
        RD: begin
          if (we_p0) begin
            wd_p1 <= store_merge(rd, wdata_p0, size_p0, a_p0[1:0]);
            state <= WR;
          end else begin
            resp_rdata <= load_extend(rd, size_p0, a_p0[1:0], sgn_p0);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        // Stage p2: write word committed by memory at the end of this cycle.
        WR: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        // Response cycle; the next request is accepted after it.
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a behavioural 1KB byte memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;
  logic preload;
  logic [31:0] exp_rd;

  logic [7:0] mem [0:1023];
  logic [9:0] wa;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_BYTES(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd)
  );

  assign wa = {addr[9:2], 2'b00};
  assign rd = MemRead ? {mem[wa + 10'd3], mem[wa + 10'd2], mem[wa + 10'd1], mem[wa]} : 32'd0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[16]   <= 8'h83;
      mem[17]   <= 8'h82;
      mem[18]   <= 8'h81;
      mem[19]   <= 8'h80;
      mem[1023] <= 8'h7F;
    end else if (MemWrite) begin
      mem[wa]         <= wd[7:0];
      mem[wa + 10'd1] <= wd[15:8];
      mem[wa + 10'd2] <= wd[23:16];
      mem[wa + 10'd3] <= wd[31:24];
    end
    if (MemWrite)   wr_cnt   <= wr_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, scramble the inputs after accept, and
  // record per-cycle memory activity until the response (bounded).
  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wdat,
                         output int lat, output int rdc, output int wrc,
                         output logic [31:0] ad, output logic [31:0] wdo,
                         output logic errv, output logic [31:0] rdv,
                         output logic after);
    req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg;
    req_addr = a; req_wdata = wdat;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_size = 2'b11; req_sign = ~sg;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    lat = -1; rdc = 0; wrc = 0; ad = 32'd0; wdo = 32'd0; errv = 1'b0; rdv = 32'd0;
    for (int k = 1; k <= 10; k++) begin
      if (MemRead && rdc == 0)  begin rdc = k; ad = addr; end
      if (MemWrite && wrc == 0) begin wrc = k; wdo = wd; ad = addr; end
      if (resp_valid) begin lat = k; errv = resp_err; rdv = resp_rdata; break; end
      @(negedge clk);
    end
    @(negedge clk);
    after = resp_valid;
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] exp);
    int lat, rdc, wrc; logic [31:0] ad, wdo, rdv; logic errv, after;
    run_req(1'b0, sz, sg, a, 32'h0, lat, rdc, wrc, ad, wdo, errv, rdv, after);
    chk({tag, ".lat"}, 32'(lat), 32'd2);
    chk({tag, ".rdcyc"}, 32'(rdc), 32'd1);
    chk({tag, ".wrcyc"}, 32'(wrc), 32'd0);
    chk({tag, ".data"}, rdv, exp);
    chk({tag, ".err"}, {31'd0, errv}, 32'd0);
    chk({tag, ".pulse"}, {31'd0, after}, 32'd0);
    exp_rd = exp;
  endtask

  task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] wdat, input int exp_lat,
                    input logic [31:0] exp_addr, input logic [31:0] exp_wd);
    int lat, rdc, wrc; logic [31:0] ad, wdo, rdv; logic errv, after;
    run_req(1'b1, sz, 1'b0, a, wdat, lat, rdc, wrc, ad, wdo, errv, rdv, after);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdcyc"}, 32'(rdc), (exp_lat == 3) ? 32'd1 : 32'd0);
    chk({tag, ".wrcyc"}, 32'(wrc), 32'(exp_lat - 1));
    chk({tag, ".addr"}, ad, exp_addr);
    chk({tag, ".wd"}, wdo, exp_wd);
    chk({tag, ".err"}, {31'd0, errv}, 32'd0);
    chk({tag, ".rdata"}, rdv, exp_rd);
  endtask

  task automatic bad_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic [31:0] a);
    int lat, rdc, wrc; logic [31:0] ad, wdo, rdv; logic errv, after;
    run_req(we, sz, 1'b0, a, 32'h1234_5678, lat, rdc, wrc, ad, wdo, errv, rdv, after);
    chk({tag, ".lat"}, 32'(lat), 32'd1);
    chk({tag, ".rdcyc"}, 32'(rdc), 32'd0);
    chk({tag, ".wrcyc"}, 32'(wrc), 32'd0);
    chk({tag, ".err"}, {31'd0, errv}, 32'd1);
    chk({tag, ".rdata"}, rdv, exp_rd);
  endtask

  initial begin
    int lat, rdc, wrc, w0, r0;
    logic [31:0] ad, wdo, rdv;
    logic errv, after;

    rst = 1'b1; preload = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_sign = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; exp_rd = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.MemRead", {31'd0, MemRead}, 32'd0);
    chk("rst.MemWrite", {31'd0, MemWrite}, 32'd0);
    chk("rst.addr", addr, 32'd0);
    chk("rst.wd", wd, 32'd0);
    chk("rst.ready_in_rst", {31'd0, req_ready}, 32'd0);
    preload = 1'b0; rst = 1'b0;
    #1;
    chk("rst.ready_after", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    // Word load with full timing check.
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdc, wrc, ad, wdo, errv, rdv, after);
    chk("lw10.lat", 32'(lat), 32'd2);
    chk("lw10.rdcyc", 32'(rdc), 32'd1);
    chk("lw10.wrcyc", 32'(wrc), 32'd0);
    chk("lw10.addr", ad, 32'h10);
    chk("lw10.data", rdv, 32'h8081_8283);
    chk("lw10.err", {31'd0, errv}, 32'd0);
    chk("lw10.pulse", {31'd0, after}, 32'd0);
    chk("lw10.ready", {31'd0, req_ready}, 32'd1);
    exp_rd = 32'h8081_8283;

    // Sub-word loads with extension.
    ld("lb13", 2'b00, 1'b1, 32'h13, 32'hFFFF_FF80);
    ld("lbu11", 2'b00, 1'b0, 32'h11, 32'h0000_0082);
    ld("lh12", 2'b01, 1'b1, 32'h12, 32'hFFFF_8081);
    ld("lhu12", 2'b01, 1'b0, 32'h12, 32'h0000_8081);

    // Byte store via RMW, then read back.
    st("sb11", 2'b00, 32'h11, 32'h0000_00AA, 3, 32'h10, 32'h8081_AA83);
    ld("lw10b", 2'b10, 1'b0, 32'h10, 32'h8081_AA83);

    // Word store, halfword RMW on upper lane, top-of-memory byte.
    st("sw20", 2'b10, 32'h20, 32'h1234_5678, 2, 32'h20, 32'h1234_5678);
    ld("lw20", 2'b10, 1'b0, 32'h20, 32'h1234_5678);
    st("sh22", 2'b01, 32'h22, 32'h0000_BEEF, 3, 32'h20, 32'hBEEF_5678);
    ld("lh22", 2'b01, 1'b1, 32'h22, 32'hFFFF_BEEF);
    ld("lb3ff", 2'b00, 1'b1, 32'h3FF, 32'h0000_007F);

    // Misaligned word.
`ifdef MEM_MISALIGN_TRAP_EN
    bad_req("lw12", 1'b0, 2'b10, 32'h12);
`else
    ld("lw12", 2'b10, 1'b0, 32'h12, 32'h8081_AA83);
`endif

    // Range and size errors.
    bad_req("lw400", 1'b0, 2'b10, 32'h400);
    bad_req("sw400", 1'b1, 2'b10, 32'h400);
    bad_req("size11", 1'b0, 2'b11, 32'h10);

    // Reset during the RD cycle of a halfword store.
    w0 = wr_cnt; r0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_sign = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstrd.in_rd", {31'd0, MemRead}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstrd.MemWrite", {31'd0, MemWrite}, 32'd0);
    chk("rstrd.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstrd.ready_in_rst", {31'd0, req_ready}, 32'd0);
    chk("rstrd.rdata_cleared", resp_rdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("rstrd.ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rstrd.no_write", 32'(wr_cnt), 32'(w0));
    chk("rstrd.no_resp", 32'(resp_cnt), 32'(r0));
    exp_rd = 32'd0;
    ld("rstrd.mem", 2'b10, 1'b0, 32'h10, 32'h8081_AA83);

    // Reset during the WR cycle of a byte store suppresses the write.
    w0 = wr_cnt; r0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_sign = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstwr.in_rd", {31'd0, MemRead}, 32'd1);
    @(negedge clk);
    chk("rstwr.in_wr", {31'd0, MemWrite}, 32'd1);
    chk("rstwr.wd", wd, 32'h8081_AA55);
    rst = 1'b1;
    #1;
    chk("rstwr.gated", {31'd0, MemWrite}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstwr.no_write", 32'(wr_cnt), 32'(w0));
    chk("rstwr.no_resp", 32'(resp_cnt), 32'(r0));
    exp_rd = 32'd0;
    ld("rstwr.mem", 2'b10, 1'b0, 32'h10, 32'h8081_AA83);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
